// File: rtl/vreg_serial_ctrl.sv
// Master-side sequencer for the vector register file serial port (load = 16 writes, store = 16 reads).
// Optional abort support is compiled in when ABORT_EN is defined.
module vreg_serial_ctrl #(
  parameter int ELEM_W    = 16,
  parameter int NUM_ELEM  = 16,
  parameter int ADDR_W    = 3,
  parameter int SETUP_CYC = 1,
  parameter int IDLE_CYC  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       dir_i,
  input  logic [ADDR_W-1:0]          vaddr_i,
  input  logic [ELEM_W*NUM_ELEM-1:0] vec_i,
  output logic [ELEM_W*NUM_ELEM-1:0] vec_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [ADDR_W-1:0]          addr_o,
  output logic                       wr_s_o,
  output logic                       rd_s_o,
  output logic [ELEM_W-1:0]          data_in_s_o,
`ifdef ABORT_EN
  input  logic                       abort_i,
  output logic                       aborted_o,
`endif
  input  logic [ELEM_W-1:0]          data_out_s_i
);

  localparam int VEC_W    = ELEM_W * NUM_ELEM;
  localparam int CNT_W    = $clog2(NUM_ELEM);
  localparam int MAX_WAIT = (SETUP_CYC > IDLE_CYC) ? SETUP_CYC : IDLE_CYC;
  localparam int WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(NUM_ELEM - 1);
  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(SETUP_CYC - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(IDLE_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [VEC_W-1:0]  shadow_q, shadow_d;
  logic [VEC_W-1:0]  vec_out_q, vec_out_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [ELEM_W-1:0] data_in_q, data_in_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [CNT_W-1:0]  cap_idx;
`ifdef ABORT_EN
  logic              aborted_q, aborted_d;
`endif

  assign cnt_inc = cnt_q + 1'b1;
  assign cap_idx = cnt_q - 1'b1;

  // Strobes are registered so they change only on clock edges and vanish at once on reset.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    addr_d    = addr_q;
    shadow_d  = shadow_q;
    vec_out_d = vec_out_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    wr_d      = 1'b0;
    rd_d      = 1'b0;
    data_in_d = data_in_q;
    done_d    = 1'b0;
`ifdef ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_SETUP;
          dir_d    = dir_i;
          addr_d   = vaddr_i;
          shadow_d = vec_i;
          cnt_d    = '0;
          wait_d   = '0;
`ifdef ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      S_SETUP: begin
        if (wait_q == SETUP_LAST) begin
          state_d = S_XFER;
          cnt_d   = '0;
          wr_d    = ~dir_q;
          rd_d    = dir_q;
          if (!dir_q) data_in_d = shadow_q[0 +: ELEM_W];
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_XFER: begin
        // Read data lags the strobe by one cycle, so cycle k returns element k-1.
        if (dir_q && (cnt_q != '0)) vec_out_d[cap_idx*ELEM_W +: ELEM_W] = data_out_s_i;
        if (cnt_q == CNT_LAST) begin
          state_d = dir_q ? S_DRAIN : S_GAP;
          wait_d  = '0;
        end else begin
          cnt_d = cnt_inc;
          wr_d  = ~dir_q;
          rd_d  = dir_q;
          if (!dir_q) data_in_d = shadow_q[cnt_inc*ELEM_W +: ELEM_W];
        end
      end
      S_DRAIN: begin
        vec_out_d[(NUM_ELEM-1)*ELEM_W +: ELEM_W] = data_out_s_i;
        state_d = S_GAP;
        wait_d  = '0;
      end
      S_GAP: begin
        if (wait_q == GAP_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef ABORT_EN
    if (abort_i && ((state_q == S_SETUP) || (state_q == S_XFER) || (state_q == S_DRAIN))) begin
      state_d   = S_GAP;
      wait_d    = '0;
      cnt_d     = cnt_q;
      wr_d      = 1'b0;
      rd_d      = 1'b0;
      vec_out_d = vec_out_q;
      aborted_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      addr_q    <= '0;
      shadow_q  <= '0;
      vec_out_q <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      data_in_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      addr_q    <= addr_d;
      shadow_q  <= shadow_d;
      vec_out_q <= vec_out_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      data_in_q <= data_in_d;
      done_q    <= done_d;
    end
  end

`ifdef ABORT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) aborted_q <= 1'b0;
    else         aborted_q <= aborted_d;
  end

  assign aborted_o = aborted_q;
`endif

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign addr_o      = addr_q;
  assign wr_s_o      = wr_q;
  assign rd_s_o      = rd_q;
  assign data_in_s_o = data_in_q;
  assign vec_o       = vec_out_q;

endmodule

// File: tb/tb_vreg_serial_ctrl.sv
// Directed bench for vreg_serial_ctrl: load, store, back-to-back, ignored Start, mid-burst reset
// and (with ABORT_EN) abort. Cycle c means the cycle after the c-th posedge following acceptance.
module tb_vreg_serial_ctrl;
  localparam int ELEM_W   = 16;
  localparam int NUM_ELEM = 16;
  localparam int ADDR_W   = 3;
  localparam int VEC_W    = ELEM_W * NUM_ELEM;

  typedef logic [VEC_W-1:0] vec_t;

  logic              clk = 1'b0;
  logic              rstN;
  logic              start;
  logic              dir;
  logic [ADDR_W-1:0] vaddr;
  vec_t              vecIn;
  vec_t              vecOut;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] addr;
  logic              wrS;
  logic              rdS;
  logic [ELEM_W-1:0] dataIn;
  logic [ELEM_W-1:0] dataOut;
`ifdef ABORT_EN
  logic              abortReq;
  logic              aborted;
`endif

  int nCompared   = 0;
  int nMismatched = 0;

  logic [ELEM_W-1:0] rfBase;
  logic [3:0]        rfIdx;
  vec_t              expVec;

  vreg_serial_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .start_i      (start),
    .dir_i        (dir),
    .vaddr_i      (vaddr),
    .vec_i        (vecIn),
    .vec_o        (vecOut),
    .busy_o       (busy),
    .done_o       (done),
    .addr_o       (addr),
    .wr_s_o       (wrS),
    .rd_s_o       (rdS),
    .data_in_s_o  (dataIn),
`ifdef ABORT_EN
    .abort_i      (abortReq),
    .aborted_o    (aborted),
`endif
    .data_out_s_i (dataOut)
  );

  always #5 clk = ~clk;

  // Register file read side: element index advances per read strobe, restarts when the strobe drops.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rfIdx   <= 4'd0;
      dataOut <= '0;
    end else if (rdS) begin
      dataOut <= rfBase + 16'(rfIdx);
      rfIdx   <= rfIdx + 4'd1;
    end else begin
      rfIdx <= 4'd0;
    end
  end

  function automatic vec_t mkVec(input logic [ELEM_W-1:0] base);
    vec_t v;
    for (int k = 0; k < NUM_ELEM; k++) v[k*ELEM_W +: ELEM_W] = base + 16'(k);
    return v;
  endfunction

  task automatic applyStimulus(input logic s, input logic d, input logic [ADDR_W-1:0] a, input vec_t v);
    start = s;
    dir   = d;
    vaddr = a;
    vecIn = v;
  endtask

  task automatic checkOutput(input string tag, input vec_t observed, input vec_t expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rstN   = 1'b0;
    rfBase = 16'h1230;
`ifdef ABORT_EN
    abortReq = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0, 3'd0, '0);

    // Reset state
    #2;
    checkOutput("rst busy", vec_t'(busy), vec_t'(0));
    checkOutput("rst done", vec_t'(done), vec_t'(0));
    checkOutput("rst wr", vec_t'(wrS), vec_t'(0));
    checkOutput("rst rd", vec_t'(rdS), vec_t'(0));
    checkOutput("rst addr", vec_t'(addr), vec_t'(0));
    checkOutput("rst data", vec_t'(dataIn), vec_t'(0));
    checkOutput("rst vec", vecOut, '0);
    #10 rstN = 1'b1;

    // Load to register 2; a Start with other address/data in cycle 5 must be ignored
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 3'd2, mkVec(16'hA000));
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      if (c == 1) applyStimulus(1'b0, 1'b0, 3'd2, mkVec(16'hA000));
      if (c == 5) applyStimulus(1'b1, 1'b0, 3'd7, {16{16'hFFFF}});
      if (c == 6) applyStimulus(1'b0, 1'b0, 3'd0, '0);
      checkOutput($sformatf("load wr c%0d", c), vec_t'(wrS), vec_t'(c >= 2 && c <= 17));
      checkOutput($sformatf("load rd c%0d", c), vec_t'(rdS), vec_t'(0));
      checkOutput($sformatf("load addr c%0d", c), vec_t'(addr), vec_t'(2));
      checkOutput($sformatf("load busy c%0d", c), vec_t'(busy), vec_t'(c <= 18));
      checkOutput($sformatf("load done c%0d", c), vec_t'(done), vec_t'(c == 19));
      if (c >= 2 && c <= 17)
        checkOutput($sformatf("load data c%0d", c), vec_t'(dataIn), vec_t'(16'hA000 + 16'(c - 2)));
    end
    checkOutput("load leaves vec_out", vecOut, '0);

    // Store from register 5
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 3'd5, mkVec(16'h5555));
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) applyStimulus(1'b0, 1'b0, 3'd0, '0);
      checkOutput($sformatf("store rd c%0d", c), vec_t'(rdS), vec_t'(c >= 2 && c <= 17));
      checkOutput($sformatf("store wr c%0d", c), vec_t'(wrS), vec_t'(0));
      checkOutput($sformatf("store addr c%0d", c), vec_t'(addr), vec_t'(5));
      checkOutput($sformatf("store busy c%0d", c), vec_t'(busy), vec_t'(c <= 19));
      checkOutput($sformatf("store done c%0d", c), vec_t'(done), vec_t'(c == 20));
    end
    checkOutput("store vec_out", vecOut, mkVec(16'h1230));

    // Back-to-back loads: Start held high, second request presented late in the first burst
    applyStimulus(1'b1, 1'b0, 3'd1, mkVec(16'hB000));
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      if (c == 18) applyStimulus(1'b1, 1'b0, 3'd3, mkVec(16'hC000));
      checkOutput($sformatf("b2b1 wr c%0d", c), vec_t'(wrS), vec_t'(c >= 2 && c <= 17));
      checkOutput($sformatf("b2b1 addr c%0d", c), vec_t'(addr), vec_t'(1));
      checkOutput($sformatf("b2b1 done c%0d", c), vec_t'(done), vec_t'(c == 19));
      checkOutput($sformatf("b2b1 busy c%0d", c), vec_t'(busy), vec_t'(c <= 18));
      if (c >= 2 && c <= 17)
        checkOutput($sformatf("b2b1 data c%0d", c), vec_t'(dataIn), vec_t'(16'hB000 + 16'(c - 2)));
    end
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      if (c == 1) applyStimulus(1'b0, 1'b0, 3'd0, '0);
      checkOutput($sformatf("b2b2 wr c%0d", c), vec_t'(wrS), vec_t'(c >= 2 && c <= 17));
      checkOutput($sformatf("b2b2 addr c%0d", c), vec_t'(addr), vec_t'(3));
      checkOutput($sformatf("b2b2 done c%0d", c), vec_t'(done), vec_t'(c == 19));
      if (c >= 2 && c <= 17)
        checkOutput($sformatf("b2b2 data c%0d", c), vec_t'(dataIn), vec_t'(16'hC000 + 16'(c - 2)));
    end
    checkOutput("b2b vec_out", vecOut, mkVec(16'h1230));

    // Reset in store XFER element 8 (cycle 10)
    rfBase = 16'h4560;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 3'd6, '0);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) applyStimulus(1'b0, 1'b0, 3'd0, '0);
    end
    checkOutput("pre-rst rd", vec_t'(rdS), vec_t'(1));
    #2 rstN = 1'b0;
    #1;
    checkOutput("midrst rd", vec_t'(rdS), vec_t'(0));
    checkOutput("midrst wr", vec_t'(wrS), vec_t'(0));
    checkOutput("midrst busy", vec_t'(busy), vec_t'(0));
    checkOutput("midrst done", vec_t'(done), vec_t'(0));
    checkOutput("midrst vec", vecOut, '0);
    @(posedge clk); @(posedge clk); #3;
    rstN = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("postrst done c%0d", c), vec_t'(done), vec_t'(0));
      checkOutput($sformatf("postrst busy c%0d", c), vec_t'(busy), vec_t'(0));
    end
    applyStimulus(1'b1, 1'b0, 3'd4, mkVec(16'hD000));
    for (int c = 1; c <= 19; c++) begin
      @(posedge clk); #1;
      if (c == 1) applyStimulus(1'b0, 1'b0, 3'd0, '0);
      checkOutput($sformatf("rec wr c%0d", c), vec_t'(wrS), vec_t'(c >= 2 && c <= 17));
      checkOutput($sformatf("rec done c%0d", c), vec_t'(done), vec_t'(c == 19));
      if (c >= 2 && c <= 17)
        checkOutput($sformatf("rec data c%0d", c), vec_t'(dataIn), vec_t'(16'hD000 + 16'(c - 2)));
    end
    checkOutput("rec addr", vec_t'(addr), vec_t'(4));

`ifdef ABORT_EN
    // Full store, then a store aborted in XFER element 5 (cycle 7)
    rfBase = 16'h1230;
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 3'd5, '0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) applyStimulus(1'b0, 1'b0, 3'd0, '0);
    end
    checkOutput("abt pre vec", vecOut, mkVec(16'h1230));
    rfBase = 16'h7770;
    applyStimulus(1'b1, 1'b1, 3'd5, '0);
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 1) applyStimulus(1'b0, 1'b0, 3'd0, '0);
      if (c == 7) abortReq = 1'b1;
      if (c == 8) abortReq = 1'b0;
      checkOutput($sformatf("abt rd c%0d", c), vec_t'(rdS), vec_t'(c >= 2 && c <= 7));
      checkOutput($sformatf("abt done c%0d", c), vec_t'(done), vec_t'(c == 9));
      checkOutput($sformatf("abt flag c%0d", c), vec_t'(aborted), vec_t'(c >= 8));
    end
    checkOutput("abt busy", vec_t'(busy), vec_t'(0));
    expVec = mkVec(16'h1230);
    for (int k = 0; k < 4; k++) expVec[k*ELEM_W +: ELEM_W] = 16'h7770 + 16'(k);
    checkOutput("abt vec", vecOut, expVec);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
